pipe_sequencer: RTL and testbench

//  Pipeline sequencer for the FETCH/EX/WB CPU. Sits between control_unit and datapath.

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/raw_hazard_detect.sv | 30 +++
 rtl/pipe_sequencer.sv | 211 +++++++++++++++++++++
 tb/tb_pipe_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared types for the FETCH/EX/WB CPU pipeline control.
//   pcsrc_e      : PC source selection driven into the datapath
//   seq_state_e  : states of the pipeline sequencer FSM
//   pcsrc_sel()  : priority encoder for control transfers (jalr > jal > branch)
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    PCSRC_SEQ  = 2'd0,   // PC + 4
    PCSRC_BR   = 2'd1,   // branch target
    PCSRC_JAL  = 2'd2,   // jal target
    PCSRC_JALR = 2'd3    // jalr target (R_EX)
  } pcsrc_e;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    REDIRECT = 2'd1,
    MCWAIT   = 2'd2
  } seq_state_e;

  // Several transfer flags may be set at once; the most specific one wins.
  function automatic pcsrc_e pcsrc_sel(input logic jalr, input logic jal,
                                       input logic br_taken);
    pcsrc_e sel;
    sel = PCSRC_SEQ;
    if (jalr)          sel = PCSRC_JALR;
    else if (jal)      sel = PCSRC_JAL;
    else if (br_taken) sel = PCSRC_BR;
    return sel;
  endfunction

endpackage

// File: rtl/raw_hazard_detect.sv
// -----------------------------------------------------------------------------
// raw_hazard_detect
// Combinational read-after-write compare between the instruction in FETCH and
// the producer in EX. x0 is never a producer.
//   valid_i     in  1      FETCH holds a valid instruction
//   regwrite_i  in  1      EX instruction writes rd_i
//   rs1_i,rs2_i in  REG_W  source registers in FETCH
//   rd_i        in  REG_W  destination register in EX
//   hit_rs1_o   out 1      rs1_i depends on the EX result
//   hit_rs2_o   out 1      rs2_i depends on the EX result
// -----------------------------------------------------------------------------
module raw_hazard_detect
  import cpu_pkg::*;
(
  input  logic             valid_i,
  input  logic             regwrite_i,
  input  logic [REG_W-1:0] rs1_i,
  input  logic [REG_W-1:0] rs2_i,
  input  logic [REG_W-1:0] rd_i,
  output logic             hit_rs1_o,
  output logic             hit_rs2_o
);

  logic producer;

  assign producer  = valid_i & regwrite_i & (rd_i != '0);
  assign hit_rs1_o = producer & (rs1_i == rd_i);
  assign hit_rs2_o = producer & (rs2_i == rd_i);

endmodule

// File: rtl/pipe_sequencer.sv
// -----------------------------------------------------------------------------
// pipe_sequencer
// Pipeline sequencer for the FETCH/EX/WB CPU, between control_unit and
// datapath. Resolves control transfers, RAW hazards and multi-cycle EX ops.
//
// Optional feature macro: HAZARD_FWD_EN
//   defined     : RAW hazards are forwarded (fwd_rs1/fwd_rs2 ports), no stall
//   not defined : RAW hazard stalls FETCH and bubbles EX for one cycle
//
// Parameters
//   FLUSH_CYCLES  bubbles after a taken transfer (1..7)
//   MC_TIMEOUT    cycles waited for mc_done before abort (>=2)
//   CNT_W         width of the stall performance counter
// Ports
//   clk, rst (async, active-low)
//   valid_F, rs1_F, rs2_F            instruction in FETCH
//   rd_EX, regwrite_EX               producer in EX
//   branch_EX, jal_EX, jalr_EX, R_EX control transfer in EX (R_EX[0] = taken)
//   mc_req_EX, mc_done               multi-cycle unit handshake in
//   stall_FETCH, stall_EX, flush_F   pipeline control out
//   pcsrc_EX                         PC source select (cpu_pkg::pcsrc_e)
//   mc_start, mc_err                 multi-cycle start pulse / sticky timeout
//   stall_cnt                        saturating count of stall_FETCH cycles
//   fwd_rs1, fwd_rs2                 forwarding selects (HAZARD_FWD_EN only)
// -----------------------------------------------------------------------------
module pipe_sequencer
  import cpu_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MC_TIMEOUT   = 64,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_F,
  input  logic [REG_W-1:0] rs1_F,
  input  logic [REG_W-1:0] rs2_F,
  input  logic [REG_W-1:0] rd_EX,
  input  logic             regwrite_EX,
  input  logic             branch_EX,
  input  logic             jal_EX,
  input  logic             jalr_EX,
  input  logic [31:0]      R_EX,
  input  logic             mc_req_EX,
  input  logic             mc_done,
  output logic             stall_FETCH,
  output logic             stall_EX,
  output logic             flush_F,
  output logic [1:0]       pcsrc_EX,
  output logic             mc_start,
  output logic             mc_err,
`ifdef HAZARD_FWD_EN
  output logic             fwd_rs1,
  output logic             fwd_rs2,
`endif
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int FLUSH_W = 3;
  localparam int TIMER_W = $clog2(MC_TIMEOUT);

  seq_state_e         state_q;
  logic [FLUSH_W-1:0] flush_ctr_q;
  logic [TIMER_W-1:0] timer_q;
  logic               mc_start_q;
  logic               mc_err_q;
  logic               raw_hold_q;
  logic [CNT_W-1:0]   stall_cnt_q;

  logic   hit_rs1, hit_rs2;
  logic   br_taken, taken;
  logic   raw_stall;
  logic   mc_done_ok;
  logic   timeout;
  pcsrc_e pcsrc_d;

  // Only the taken flag of the ALU result matters here.
  logic unused_r_ex;
  assign unused_r_ex = ^R_EX[31:1];

  raw_hazard_detect u_raw (
    .valid_i    (valid_F),
    .regwrite_i (regwrite_EX),
    .rs1_i      (rs1_F),
    .rs2_i      (rs2_F),
    .rd_i       (rd_EX),
    .hit_rs1_o  (hit_rs1),
    .hit_rs2_o  (hit_rs2)
  );

  assign br_taken = branch_EX & R_EX[0];
  assign taken    = jal_EX | jalr_EX | br_taken;

`ifdef HAZARD_FWD_EN
  assign raw_stall = 1'b0;
  assign fwd_rs1   = hit_rs1;
  assign fwd_rs2   = hit_rs2;
`else
  // raw_hold_q blocks a second back-to-back stall so a hazard costs one cycle.
  assign raw_stall = (hit_rs1 | hit_rs2) & ~raw_hold_q;
`endif

  // A done pulse coinciding with the start pulse belongs to no request.
  assign mc_done_ok = mc_done & ~mc_start_q;
  assign timeout    = (timer_q == TIMER_W'(MC_TIMEOUT - 1));

  // Pipeline controls are Mealy outputs: the datapath must react in the same
  // cycle the EX instruction is seen.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    stall_FETCH = 1'b0;
    stall_EX    = 1'b0;
    flush_F     = 1'b0;
    pcsrc_d     = PCSRC_SEQ;
    if (!rst) begin
      stall_FETCH = 1'b1;
      stall_EX    = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (mc_req_EX) begin
            stall_FETCH = 1'b1;
          end else if (taken) begin
            flush_F = 1'b1;
            pcsrc_d = pcsrc_sel(jalr_EX, jal_EX, br_taken);
          end else if (raw_stall) begin
            stall_FETCH = 1'b1;
            stall_EX    = 1'b1;
          end
        end
        REDIRECT: begin
          flush_F  = 1'b1;
          stall_EX = 1'b1;
        end
        MCWAIT: begin
          // EX is held by the datapath while the multi-cycle unit runs.
          stall_FETCH = 1'b1;
          if (!mc_done_ok && timeout) flush_F = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign pcsrc_EX = pcsrc_d;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      flush_ctr_q <= '0;
      timer_q     <= '0;
      mc_start_q  <= 1'b0;
      mc_err_q    <= 1'b0;
      raw_hold_q  <= 1'b0;
    end else begin
      mc_start_q <= 1'b0;
      raw_hold_q <= 1'b0;
      case (state_q)
        RUN: begin
          timer_q <= '0;
          if (mc_req_EX) begin
            state_q    <= MCWAIT;
            mc_start_q <= 1'b1;
          end else if (taken) begin
            if (FLUSH_CYCLES > 1) begin
              state_q     <= REDIRECT;
              flush_ctr_q <= FLUSH_W'(FLUSH_CYCLES - 1);
            end
          end else if (raw_stall) begin
            raw_hold_q <= 1'b1;
          end
        end
        REDIRECT: begin
          flush_ctr_q <= flush_ctr_q - 1'b1;
          if (flush_ctr_q == FLUSH_W'(1)) state_q <= RUN;
        end
        MCWAIT: begin
          // Done has priority over a timeout in the same cycle.
          if (mc_done_ok) begin
            state_q <= RUN;
            timer_q <= '0;
          end else if (timeout) begin
            state_q  <= RUN;
            mc_err_q <= 1'b1;
            timer_q  <= '0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  // Saturating performance counter of FETCH stall cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
    end else if (stall_FETCH && (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign mc_start  = mc_start_q;
  assign mc_err    = mc_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pipe_sequencer
// Directed bench for pipe_sequencer (FLUSH_CYCLES=2). A second instance with a
// 4-bit counter shares the stimulus to exercise counter saturation.
// Expected outputs per cycle are queued when the stimulus is driven and
// compared at the following falling edge. Honours HAZARD_FWD_EN.
// -----------------------------------------------------------------------------
module tb_pipe_sequencer;
  import cpu_pkg::*;

  typedef struct packed {
    logic       sf;   // stall_FETCH
    logic       se;   // stall_EX
    logic       fl;   // flush_F
    logic [1:0] pc;   // pcsrc_EX
    logic       ms;   // mc_start
    logic       me;   // mc_err
    logic       f1;   // fwd_rs1
    logic       f2;   // fwd_rs2
  } exp_t;

  logic        clk, rst;
  logic        valid_F, regwrite_EX, branch_EX, jal_EX, jalr_EX, mc_req_EX, mc_done;
  logic [4:0]  rs1_F, rs2_F, rd_EX;
  logic [31:0] R_EX;

  logic        stall_FETCH, stall_EX, flush_F, mc_start, mc_err;
  logic [1:0]  pcsrc_EX;
  logic [15:0] stall_cnt;

  logic        s_stall_FETCH, s_stall_EX, s_flush_F, s_mc_start, s_mc_err;
  logic [1:0]  s_pcsrc_EX;
  logic [3:0]  s_stall_cnt;
`ifdef HAZARD_FWD_EN
  logic        fwd_rs1, fwd_rs2, s_fwd_rs1, s_fwd_rs2;
`endif

  int   total = 0;
  int   bad   = 0;
  int   exp_cnt = 0;
  exp_t exp_q[$];

  pipe_sequencer #(.FLUSH_CYCLES(2), .MC_TIMEOUT(64), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .valid_F(valid_F), .rs1_F(rs1_F), .rs2_F(rs2_F),
    .rd_EX(rd_EX), .regwrite_EX(regwrite_EX), .branch_EX(branch_EX),
    .jal_EX(jal_EX), .jalr_EX(jalr_EX), .R_EX(R_EX), .mc_req_EX(mc_req_EX),
    .mc_done(mc_done), .stall_FETCH(stall_FETCH), .stall_EX(stall_EX),
    .flush_F(flush_F), .pcsrc_EX(pcsrc_EX), .mc_start(mc_start), .mc_err(mc_err),
`ifdef HAZARD_FWD_EN
    .fwd_rs1(fwd_rs1), .fwd_rs2(fwd_rs2),
`endif
    .stall_cnt(stall_cnt)
  );

  pipe_sequencer #(.FLUSH_CYCLES(2), .MC_TIMEOUT(64), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .valid_F(valid_F), .rs1_F(rs1_F), .rs2_F(rs2_F),
    .rd_EX(rd_EX), .regwrite_EX(regwrite_EX), .branch_EX(branch_EX),
    .jal_EX(jal_EX), .jalr_EX(jalr_EX), .R_EX(R_EX), .mc_req_EX(mc_req_EX),
    .mc_done(mc_done), .stall_FETCH(s_stall_FETCH), .stall_EX(s_stall_EX),
    .flush_F(s_flush_F), .pcsrc_EX(s_pcsrc_EX), .mc_start(s_mc_start),
    .mc_err(s_mc_err),
`ifdef HAZARD_FWD_EN
    .fwd_rs1(s_fwd_rs1), .fwd_rs2(s_fwd_rs2),
`endif
    .stall_cnt(s_stall_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t mk(input logic sf, input logic se, input logic fl,
                              input logic [1:0] pc, input logic ms, input logic me);
    exp_t e;
    e = '{sf: sf, se: se, fl: fl, pc: pc, ms: ms, me: me, f1: 1'b0, f2: 1'b0};
    return e;
  endfunction

  task automatic idle_inputs();
    valid_F = 0; regwrite_EX = 0; branch_EX = 0; jal_EX = 0; jalr_EX = 0;
    mc_req_EX = 0; mc_done = 0; rs1_F = 0; rs2_F = 0; rd_EX = 0; R_EX = 0;
  endtask

  // Inputs for this cycle are already driven; queue the expectation, compare
  // at the falling edge, then advance to just after the next rising edge.
  task automatic cyc(input string name, input exp_t e);
    exp_t x;
    int   sat;
    exp_q.push_back(e);
    @(negedge clk);
    x = exp_q.pop_front();
    check({name, ".stall_FETCH"}, 32'(stall_FETCH), 32'(x.sf));
    check({name, ".stall_EX"},    32'(stall_EX),    32'(x.se));
    check({name, ".flush_F"},     32'(flush_F),     32'(x.fl));
    check({name, ".pcsrc_EX"},    32'(pcsrc_EX),    32'(x.pc));
    check({name, ".mc_start"},    32'(mc_start),    32'(x.ms));
    check({name, ".mc_err"},      32'(mc_err),      32'(x.me));
`ifdef HAZARD_FWD_EN
    check({name, ".fwd_rs1"},     32'(fwd_rs1),     32'(x.f1));
    check({name, ".fwd_rs2"},     32'(fwd_rs2),     32'(x.f2));
`endif
    check({name, ".stall_cnt"},   32'(stall_cnt),   32'(exp_cnt));
    sat = (exp_cnt > 15) ? 15 : exp_cnt;
    check({name, ".stall_cnt_sat"}, 32'(s_stall_cnt), 32'(sat));
    if (x.sf && rst) exp_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    idle_inputs();
    rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset holds the pipe regardless of inputs.
    mc_req_EX = 1; jal_EX = 1; branch_EX = 1; R_EX = 32'h1;
    cyc("reset_a", mk(1, 1, 0, 0, 0, 0));
    idle_inputs();
    valid_F = 1; regwrite_EX = 1; rd_EX = 5'd7; rs1_F = 5'd7; jalr_EX = 1;
    cyc("reset_b", mk(1, 1, 0, 0, 0, 0));

    idle_inputs(); rst = 1'b1;
    cyc("idle", mk(0, 0, 0, 0, 0, 0));

    // Not-taken branch: only R_EX[0] decides.
    branch_EX = 1; R_EX = 32'hFFFF_FFFE;
    cyc("br_nt", mk(0, 0, 0, 0, 0, 0));

    // Taken branch: flush this cycle and one redirect cycle; jal held during
    // the redirect must not leak into pcsrc.
    branch_EX = 1; R_EX = 32'h1;
    cyc("br_t", mk(0, 0, 1, PCSRC_BR, 0, 0));
    idle_inputs(); jal_EX = 1;
    cyc("br_t_redir", mk(0, 1, 1, PCSRC_SEQ, 0, 0));
    idle_inputs();
    cyc("br_t_run", mk(0, 0, 0, 0, 0, 0));

    jal_EX = 1;
    cyc("jal", mk(0, 0, 1, PCSRC_JAL, 0, 0));
    idle_inputs();
    cyc("jal_redir", mk(0, 1, 1, PCSRC_SEQ, 0, 0));

    jalr_EX = 1; jal_EX = 1; branch_EX = 1; R_EX = 32'h1;
    cyc("jalr_prio", mk(0, 0, 1, PCSRC_JALR, 0, 0));
    idle_inputs();
    cyc("jalr_redir", mk(0, 1, 1, PCSRC_SEQ, 0, 0));

    jal_EX = 1; branch_EX = 1; R_EX = 32'h3;
    cyc("jal_prio", mk(0, 0, 1, PCSRC_JAL, 0, 0));
    idle_inputs();
    cyc("jal_prio_redir", mk(0, 1, 1, PCSRC_SEQ, 0, 0));
    cyc("post_redir", mk(0, 0, 0, 0, 0, 0));

    // RAW on rs2, held for two cycles.
    valid_F = 1; regwrite_EX = 1; rd_EX = 5'd5; rs1_F = 5'd3; rs2_F = 5'd5;
`ifdef HAZARD_FWD_EN
    e = mk(0, 0, 0, 0, 0, 0); e.f2 = 1;
    cyc("raw_rs2", e);
    cyc("raw_rs2_again", e);
`else
    cyc("raw_rs2", mk(1, 1, 0, 0, 0, 0));
    cyc("raw_rs2_again", mk(0, 0, 0, 0, 0, 0));
`endif

    // RAW on rs1.
    idle_inputs(); valid_F = 1; regwrite_EX = 1; rd_EX = 5'd31; rs1_F = 5'd31; rs2_F = 5'd1;
`ifdef HAZARD_FWD_EN
    e = mk(0, 0, 0, 0, 0, 0); e.f1 = 1;
    cyc("raw_rs1", e);
`else
    cyc("raw_rs1", mk(1, 1, 0, 0, 0, 0));
`endif

    // x0 is never a hazard; neither is an invalid FETCH slot or no regwrite.
    idle_inputs(); valid_F = 1; regwrite_EX = 1; rd_EX = 5'd0; rs1_F = 5'd0; rs2_F = 5'd0;
    cyc("raw_x0", mk(0, 0, 0, 0, 0, 0));
    idle_inputs(); regwrite_EX = 1; rd_EX = 5'd9; rs1_F = 5'd9;
    cyc("raw_invalid", mk(0, 0, 0, 0, 0, 0));
    idle_inputs(); valid_F = 1; rd_EX = 5'd9; rs2_F = 5'd9;
    cyc("raw_no_wr", mk(0, 0, 0, 0, 0, 0));

    // Transfer beats RAW.
    idle_inputs(); valid_F = 1; regwrite_EX = 1; rd_EX = 5'd4; rs1_F = 5'd4; jal_EX = 1;
    e = mk(0, 0, 1, PCSRC_JAL, 0, 0);
`ifdef HAZARD_FWD_EN
    e.f1 = 1;
`endif
    cyc("jal_over_raw", e);
    idle_inputs();
    cyc("jal_over_raw_redir", mk(0, 1, 1, PCSRC_SEQ, 0, 0));

    // Multi-cycle op beats a transfer; done pulse in the start cycle is
    // ignored; done after 10 cycles gives 11 stall cycles.
    mc_req_EX = 1; jal_EX = 1;
    cyc("mc_req", mk(1, 0, 0, 0, 0, 0));
    idle_inputs(); mc_done = 1;
    cyc("mc_start", mk(1, 0, 0, 0, 1, 0));
    mc_done = 0;
    for (int i = 2; i < 10; i++) cyc("mc_wait", mk(1, 0, 0, 0, 0, 0));
    mc_done = 1;
    cyc("mc_done", mk(1, 0, 0, 0, 0, 0));
    mc_done = 0;
    cyc("mc_after", mk(0, 0, 0, 0, 0, 0));

    // Done and timeout in the same cycle: done wins, no error.
    mc_req_EX = 1;
    cyc("mc2_req", mk(1, 0, 0, 0, 0, 0));
    mc_req_EX = 0;
    for (int i = 0; i < 63; i++) cyc("mc2_wait", mk(1, 0, 0, 0, (i == 0), 0));
    mc_done = 1;
    cyc("mc2_done_at_to", mk(1, 0, 0, 0, 0, 0));
    mc_done = 0;
    cyc("mc2_after", mk(0, 0, 0, 0, 0, 0));

    // No done at all: abort on the 64th wait cycle with a flush.
    mc_req_EX = 1;
    cyc("mc3_req", mk(1, 0, 0, 0, 0, 0));
    mc_req_EX = 0;
    for (int i = 0; i < 63; i++) cyc("mc3_wait", mk(1, 0, 0, 0, (i == 0), 0));
    cyc("mc3_timeout", mk(1, 0, 1, 0, 0, 0));
    cyc("mc3_err", mk(0, 0, 0, 0, 0, 1));
    cyc("mc3_err_sticky", mk(0, 0, 0, 0, 0, 1));

    // Reset in the middle of MCWAIT clears everything at once.
    mc_req_EX = 1;
    cyc("mc4_req", mk(1, 0, 0, 0, 0, 1));
    mc_req_EX = 0;
    cyc("mc4_start", mk(1, 0, 0, 0, 1, 1));
    cyc("mc4_wait", mk(1, 0, 0, 0, 0, 1));
    rst = 1'b0; exp_cnt = 0;
    cyc("mc4_rst", mk(1, 1, 0, 0, 0, 0));
    rst = 1'b1;
    cyc("mc4_released", mk(0, 0, 0, 0, 0, 0));

    // Reset during a redirect suppresses the flush.
    branch_EX = 1; R_EX = 32'h1;
    cyc("redir_br", mk(0, 0, 1, PCSRC_BR, 0, 0));
    idle_inputs(); rst = 1'b0; exp_cnt = 0;
    cyc("redir_rst", mk(1, 1, 0, 0, 0, 0));
    rst = 1'b1;
    cyc("redir_released", mk(0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
